// File: rtl/mdu.sv
// Multiply/divide unit: iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO
// result registers and direct MTHI/MTLO writes. A multiply or divide takes
// one accept cycle, 32 iteration cycles and one result-write cycle.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_w,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] data_write,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_res;   // product / quotient must be negated
    logic             neg_rem;   // remainder takes the dividend's sign
    logic             dz_pend;   // zero-divisor start seen, report next edge
    logic [WIDTH-1:0] m;         // multiplicand (mul) or divisor (div) magnitude
    // Shared working register: mul = {partial product, multiplier},
    // div = {remainder, dividend shifting into quotient}.
    logic [2*WIDTH:0] p;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH:0]   p_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    // Operand magnitudes, one iteration step, and sign-corrected results
    always_comb begin
        a_neg     = op[0] & src_a[WIDTH-1];
        b_neg     = op[0] & src_b[WIDTH-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;
        mul_sum   = p[2*WIDTH:WIDTH] + (p[0] ? {1'b0, m} : '0);
        div_shift = p[2*WIDTH-1:WIDTH-1];
        div_diff  = {1'b0, div_shift} - {2'b00, m};
        if (is_div) begin
            // Restoring step: keep the shifted remainder when the trial borrows.
            p_next = {(div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0]),
                      p[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end else begin
            p_next = {1'b0, mul_sum, p[WIDTH-1:1]};
        end
        prod = neg_res ? -p[2*WIDTH-1:0] : p[2*WIDTH-1:0];
        quo  = neg_res ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem  = neg_rem ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_pend  <= 1'b0;
            m        <= '0;
            p        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    dz_pend <= 1'b0;
                    if (dz_pend) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end
                    if (start) begin
                        if (op[1] && src_b == '0) begin
                            dz_pend <= 1'b1;
                        end else begin
                            state   <= CALC;
                            busy    <= 1'b1;
                            cnt     <= '0;
                            is_div  <= op[1];
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            m       <= op[1] ? b_mag : a_mag;
                            p       <= {{(WIDTH+1){1'b0}}, (op[1] ? a_mag : b_mag)};
                        end
                    end else if (hilo_w) begin
                        if (hilo_sel) hi <= data_write;
                        else          lo <= data_write;
                    end
                end
                CALC: begin
                    p   <= p_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIN;
                end
                FIN: begin
                    if (is_div) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        hilo_w = 1'b0;
    logic        hilo_sel = 1'b0;
    logic [31:0] data_write = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    // Architectural HI/LO as the bench expects them
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    // Observations collected by run_op
    int   obs_lat, obs_busy, obs_done, obs_dz_bad;
    logic obs_dz;

    mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hilo_w(hilo_w), .hilo_sel(hilo_sel),
        .data_write(data_write), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] ref_hilo(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        int ia, ib;
        longint sa, sb;
        logic [63:0] r;
        ia = a; ib = b;
        sa = ia; sb = ib;
        case (o)
            2'b00: r = {32'b0, a} * {32'b0, b};
            2'b01: r = 64'(sa * sb);
            2'b10: r = {a % b, a / b};
            default: begin
                r[31:0]  = 32'(sa / sb);
                r[63:32] = 32'(sa % sb);
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Start one operation (edge N = next rising edge), then watch 40 more edges
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hilo_w = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
        obs_lat = -1; obs_busy = 0; obs_done = 0; obs_dz = 1'b0; obs_dz_bad = 0;
        for (int e = 0; e <= 40; e++) begin
            if (busy) obs_busy++;
            if (done) begin
                obs_done++;
                if (obs_lat < 0) begin
                    obs_lat = e;
                    obs_dz  = div_zero;
                end
            end
            if (!done && div_zero) obs_dz_bad++;
            if (e < 40) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h expected 0", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h expected 0", lo); end
        start = 1'b0;
        rst = 1'b1;
        exp_hi = '0; exp_lo = '0;
    endtask

    // Spec-given corner values, expected constants written out by hand
    task automatic test_directed();
        logic [1:0]  t_op [5];
        logic [31:0] t_a [5], t_b [5], t_hi [5], t_lo [5];
        t_op[0] = 2'b00; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'hFFFF_FFFF; t_hi[0] = 32'hFFFF_FFFE; t_lo[0] = 32'h0000_0001;
        t_op[1] = 2'b01; t_a[1] = 32'hFFFF_FFFD; t_b[1] = 32'd5;         t_hi[1] = 32'hFFFF_FFFF; t_lo[1] = 32'hFFFF_FFF1;
        t_op[2] = 2'b11; t_a[2] = 32'hFFFF_FFF9; t_b[2] = 32'd2;         t_hi[2] = 32'hFFFF_FFFF; t_lo[2] = 32'hFFFF_FFFD;
        t_op[3] = 2'b11; t_a[3] = 32'h8000_0000; t_b[3] = 32'hFFFF_FFFF; t_hi[3] = 32'h0000_0000; t_lo[3] = 32'h8000_0000;
        t_op[4] = 2'b10; t_a[4] = 32'd100;       t_b[4] = 32'd7;         t_hi[4] = 32'd2;         t_lo[4] = 32'd14;
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_a[i], t_b[i]);
            vectors++; if (obs_lat !== 33) begin miscompares++; $display("FAIL dir_latency[%0d]: got %0d expected 33", i, obs_lat); end
            vectors++; if (obs_busy !== 33) begin miscompares++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected 33", i, obs_busy); end
            vectors++; if (obs_dz !== 1'b0) begin miscompares++; $display("FAIL dir_div_zero[%0d]: got %b expected 0", i, obs_dz); end
            vectors++; if (hi !== t_hi[i]) begin miscompares++; $display("FAIL dir_hi[%0d]: got %h expected %h", i, hi, t_hi[i]); end
            vectors++; if (lo !== t_lo[i]) begin miscompares++; $display("FAIL dir_lo[%0d]: got %h expected %h", i, lo, t_lo[i]); end
            exp_hi = t_hi[i]; exp_lo = t_lo[i];
        end
    endtask

    task automatic test_hilo_divzero();
        hilo_w = 1'b1; hilo_sel = 1'b0; data_write = 32'h0000_1234;
        @(posedge clk); #1;
        hilo_sel = 1'b1; data_write = 32'hABCD_0000;
        vectors++; if (lo !== 32'h0000_1234) begin miscompares++; $display("FAIL mtlo_value: got %h expected 00001234", lo); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mtlo_done: got %b expected 0", done); end
        @(posedge clk); #1;
        hilo_w = 1'b0;
        vectors++; if (hi !== 32'hABCD_0000) begin miscompares++; $display("FAIL mthi_value: got %h expected abcd0000", hi); end
        exp_lo = 32'h0000_1234; exp_hi = 32'hABCD_0000;
        run_op(2'b10, 32'd10, 32'd0);
        vectors++; if (obs_lat !== 1) begin miscompares++; $display("FAIL dz_latency: got %0d expected 1", obs_lat); end
        vectors++; if (obs_dz !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b expected 1", obs_dz); end
        vectors++; if (obs_busy !== 0) begin miscompares++; $display("FAIL dz_busy: got %0d expected 0", obs_busy); end
        vectors++; if (obs_done !== 1) begin miscompares++; $display("FAIL dz_done_count: got %0d expected 1", obs_done); end
        vectors++; if (lo !== exp_lo) begin miscompares++; $display("FAIL dz_lo_kept: got %h expected %h", lo, exp_lo); end
        vectors++; if (hi !== exp_hi) begin miscompares++; $display("FAIL dz_hi_kept: got %h expected %h", hi, exp_hi); end
        // start and hilo_w together: the write is dropped
        hilo_w = 1'b1; hilo_sel = 1'b0; data_write = 32'h0000_9999;
        run_op(2'b00, 32'd3, 32'd3);
        vectors++; if (lo !== 32'd9) begin miscompares++; $display("FAIL start_wins_lo: got %h expected 00000009", lo); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL start_wins_hi: got %h expected 00000000", hi); end
        exp_hi = '0; exp_lo = 32'd9;
    endtask

    task automatic test_back_to_back();
        int lat, dcount;
        op = 2'b00; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; dcount = 0;
        for (int e = 0; e <= 40; e++) begin
            if (done) begin
                dcount++;
                if (lat < 0) lat = e;
            end
            // Driven here, sampled at edge N+5
            if (e == 4) begin
                start = 1'b1; op = 2'b01; src_a = 32'd7; src_b = 32'd9;
                hilo_w = 1'b1; hilo_sel = 1'b0; data_write = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; hilo_w = 1'b0;
            end
            if (e < 40) begin
                @(posedge clk); #1;
            end
        end
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        vectors++; if (dcount !== 1) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 1", dcount); end
        vectors++; if (lo !== 32'd6) begin miscompares++; $display("FAIL b2b_lo: got %h expected 00000006", lo); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL b2b_hi: got %h expected 00000000", hi); end
        exp_hi = '0; exp_lo = 32'd6;
    endtask

    task automatic test_reset_abort();
        int dcount;
        op = 2'b00; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL abort_hi: got %h expected 0", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL abort_lo: got %h expected 0", lo); end
        dcount = 0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        rst = 1'b1;
        exp_hi = '0; exp_lo = '0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        vectors++; if (dcount !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d expected 0", dcount); end
        // Release mid-cycle; run_op's start is sampled at the first edge after
        rst = 1'b0; #2;
        rst = 1'b1;
        run_op(2'b00, 32'd4, 32'd4);
        vectors++; if (obs_lat !== 33) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected 33", obs_lat); end
        vectors++; if (lo !== 32'd16) begin miscompares++; $display("FAIL post_reset_lo: got %h expected 00000010", lo); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL post_reset_hi: got %h expected 00000000", hi); end
        exp_hi = '0; exp_lo = 32'd16;
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] r;
        bit          dz;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            a = pick_operand();
            b = pick_operand();
            dz = o[1] && (b == 32'h0);
            if (!dz) begin
                r = ref_hilo(o, a, b);
                exp_hi = r[63:32];
                exp_lo = r[31:0];
            end
            run_op(o, a, b);
            vectors++; if (obs_lat !== (dz ? 1 : 33)) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, obs_lat, dz ? 1 : 33); end
            vectors++; if (obs_busy !== (dz ? 0 : 33)) begin miscompares++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", i, obs_busy, dz ? 0 : 33); end
            vectors++; if (obs_dz !== dz) begin miscompares++; $display("FAIL rand_div_zero[%0d]: got %b expected %b", i, obs_dz, dz); end
            vectors++; if (obs_done !== 1 || obs_dz_bad !== 0) begin miscompares++; $display("FAIL rand_done_pulse[%0d]: got done=%0d stray_dz=%0d expected 1/0", i, obs_done, obs_dz_bad); end
            vectors++; if (hi !== exp_hi) begin miscompares++; $display("FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi, exp_hi); end
            vectors++; if (lo !== exp_lo) begin miscompares++; $display("FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo, exp_lo); end
        end
    endtask

    // MTHI/MTLO while busy must not disturb HI/LO
    task automatic test_hilo_busy();
        op = 2'b10; src_a = 32'd50; src_b = 32'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hilo_w = 1'b1; hilo_sel = 1'b1; data_write = 32'h5555_5555;
        repeat (3) @(posedge clk);
        #1;
        hilo_w = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL busy_mthi_hi: got %h expected 00000002", hi); end
        vectors++; if (lo !== 32'd6) begin miscompares++; $display("FAIL busy_mthi_lo: got %h expected 00000006", lo); end
        exp_hi = 32'd2; exp_lo = 32'd6;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hilo_divzero();
        test_back_to_back();
        test_hilo_busy();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 src_a  input  32  rs operand, driven from the register file reg_data1.
REQ-007 src_b  input  32  rt operand, driven from the register file reg_data2.
REQ-008 hilo_w  input  1  direct write of HI or LO (MTHI/MTLO).
REQ-009 hilo_sel  input  1  0 selects LO, 1 selects HI for hilo_w.
REQ-010 data_write  input  32  value written by hilo_w.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO are updated or an operation terminates.
REQ-013 div_zero  output  1  qualifies done: the division had a zero divisor.
REQ-014 hi  output  32  HI register, registered, feeds the register-file write-data mux (MFHI).
REQ-015 lo  output  32  LO register, registered, feeds the register-file write-data mux (MFLO).

Function
REQ-016 States IDLE, CALC, FIN; IDLE->CALC on accepted start with a nonzero divisor or any multiply; CALC->FIN after 32 iterations; FIN->IDLE unconditionally.
REQ-017 An accepted start at edge N latches op, |src_a|, |src_b| and the result sign, and sets busy=1 and iteration counter=0.
REQ-018 Edges N+1..N+32 each perform one radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
REQ-019 Edge N+33 (FIN) writes HI/LO, pulses done=1 for exactly one cycle, and clears busy; the result is visible at the hi/lo outputs from edge N+33.
REQ-020 MULTU/MULT: {HI,LO} = full 64-bit product; MULT is signed two's-complement, computed on magnitudes and negated when the operand signs differ.
REQ-021 DIVU/DIV: LO=quotient, HI=remainder; DIV truncates toward zero, the remainder takes the sign of the dividend, and 0x80000000/-1 gives LO=0x80000000, HI=0.
REQ-022 Divisor zero (op[1]=1, src_b=0): the state stays IDLE; at edge N+1 done=1 and div_zero=1; HI/LO are unchanged; busy is never asserted.
REQ-023 div_zero is 0 whenever done is 0.
REQ-024 start is ignored while busy=1; the operation in flight is unaffected.
REQ-025 hilo_w in IDLE without start writes data_write to the selected register at the next edge; done is not asserted.
REQ-026 hilo_w while busy=1 is ignored.
REQ-027 If start and hilo_w are both asserted in IDLE, start wins and hilo_w is dropped.
REQ-028 Operand inputs are don't-care after the accepting edge; changes to src_a/src_b during CALC do not affect the result.

Reset
REQ-029 rst=0 immediately forces state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, and counter=0, regardless of clock.
REQ-030 Reset during CALC or FIN aborts the operation; no done pulse follows and the partial result is discarded.
REQ-031 After rst is released, the first start is accepted at the first rising edge.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at edge N+33; HI=0xFFFFFFFE, LO=0x00000001; busy high for edges N..N+32.
REQ-033 MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, div_zero=0.
REQ-035 hilo_w=1, hilo_sel=0, data_write=0x1234 -> LO=0x1234; then DIVU 10 / 0 -> done and div_zero at N+1, LO still 0x1234, busy never 1.
REQ-036 MULTU 2 x 3 started, then second start and hilo_w pulsed at N+5 -> LO=6, HI=0 at N+33, and exactly one done pulse.
REQ-037 MULTU started, rst=0 at N+10 -> hi=lo=0, busy=0 immediately, and no done pulse; after release, MULTU 4 x 4 gives LO=16.
